rank_window_ranker: RTL and testbench
=====================================

Name: rank_window_ranker

Overview:
- Upstream neighbour of rank_selector in the rank-order filter datapath.
- Keeps a sliding window of the last N input samples and computes a unique rank 0..N-1 for every window entry.
- Rank is computed by pairwise comparison and population count.
- Presents the packed window (s) and packed ranks (r) with a valid/ready handshake; rank_selector then combinationally picks the sample whose rank equals RANK_SEL.

Parameters:
- N, 3, window length (number of samples ranked); N >= 2.
- data_bits, 8, sample width, unsigned.
- rank_bits, 2, width of each rank field; must satisfy 2**rank_bits >= N.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of window fill and pipeline valids.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  data_bits  new sample, unsigned.
- out_valid  out  1  s/r hold a complete ranked window.
- out_ready  in  1  downstream consumes s/r this cycle.
- s  out  data_bits*N  window samples; field i at [data_bits*i +: data_bits], i=0 newest, i=N-1 oldest.
- r  out  rank_bits*N  ranks; field i at [rank_bits*i +: rank_bits] is the rank of s field i.

Behaviour:
- Reset: asynchronous, active-low; clk and rst_n only, as already decided. While rst_n=0: window registers, s, r, fill count, all stage valids and out_valid = 0.
  - in_ready = 0 while rst_n=0, and 1 from the first cycle after release.
- Advance rule: advance = !out_valid | out_ready. in_ready = advance.
  - The whole pipeline stalls together. No state changes while stalled, except flush.
- Accept: in_valid & in_ready at an edge.
  - Window shifts W[i] <= W[i-1] for i = 1..N-1, and W[0] <= in_data.
  - fill_cnt increments, saturating at N.
  - w_new is set if fill_cnt reaches N with this accept; otherwise w_new is cleared.
- Stage A (each advancing edge):
  - a_vld <= w_new.
  - Captures W and the comparison matrix lt[i][j] = (W[j] < W[i]) | (W[j] == W[i] & j < i) for j != i.
- Stage B (each advancing edge):
  - out_valid <= a_vld.
  - s <= stage-A window; r field i <= popcount over j of lt[i][j].
- Rank definition:
  - Rank 0 = smallest value.
  - Ties are broken so that the newer entry (lower index) gets the lower rank.
  - Ranks always form a permutation of 0..N-1.
- Latency: out_valid rises 2 edges after the accepting edge that completes the window, when unstalled. Throughput is 1 window per cycle once filled; every accept after fill produces one output.
- Fill: no output until N samples have been accepted since reset or flush.
- Backpressure: while out_valid=1 and out_ready=0, s, r and out_valid are held stable and in_ready=0.
- flush=1 at an edge (priority over accept; the sample offered that cycle is dropped):
  - fill_cnt, w_new, a_vld and out_valid <= 0.
  - Window data need not clear.
- Reset mid-operation: all valids drop immediately. After release, behaviour is identical to a power-up fill.
- Arithmetic: comparisons are unsigned on data_bits. The popcount result fits in rank_bits (max N-1).

Decomposition:
- Shared package rof_pkg:
  - clog2 function.
  - Default N, data_bits, rank_bits constants.
  - Packed-field index helpers shared with rank_selector.
- Sub-module rank_counter: one row i. Inputs are W and index i; output is rank_bits popcount of lt[i][*]. Instantiate N times in a generate loop, with its output registered in stage B.

Test Plan:
1. Reset, out_ready=1; accept 5, 1, 9 on consecutive cycles -> out_valid=1 exactly 2 cycles after the third accept; s={5,1,9} (fields 2,1,0), r={1,0,2}.
2. Ties: accept 7, 7, 7 -> r fields {2,1,0} (r0=0, r1=1, r2=2); ranks unique.
3. Partial fill: accept 2 samples then idle 10 cycles -> out_valid stays 0. A third sample 4 after 3, 8 -> s={3,8,4}, r={0,2,1}.
4. Backpressure: with the window full, stream 10, 20, 30, 40, holding out_ready=0 after the first output -> in_ready=0, s/r frozen. Release out_ready -> outputs continue in order with no loss or duplication.
5. Flush: with the window full, assert flush for 1 cycle with in_valid=1 -> out_valid=0 next cycle. The flush-cycle sample is dropped; the next output appears only after 3 fresh accepts.
6. Async reset: pull rst_n low between edges during streaming -> out_valid and in_ready drop immediately. After release, repeat scenario 1 with the same results.

Source files
------------

// File: rtl/rof_pkg.sv
// Shared definitions for the rank-order filter datapath (ranker and selector).
package rof_pkg;

  localparam int unsigned RofN        = 3;
  localparam int unsigned RofDataBits = 8;
  localparam int unsigned RofRankBits = 2;

  // Ceiling log2, never below 1 so it can size a register directly.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned res;
    int unsigned x;
    res = 0;
    x   = 1;
    while (x < v) begin
      x   = x << 1;
      res = res + 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

  // Low bit of packed field idx in a vector of width-bit fields.
  function automatic int unsigned field_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rank_counter.sv
// One rank row: counts window entries that order strictly before entry 'row'.
module rank_counter
  import rof_pkg::*;
#(
  parameter int unsigned N         = RofN,
  parameter int unsigned data_bits = RofDataBits,
  parameter int unsigned rank_bits = RofRankBits,
  parameter int unsigned row       = 0
) (
  input  logic [data_bits*N-1:0] win,
  output logic [rank_bits-1:0]   rank
);

  logic [data_bits-1:0] mine;

  assign mine = win[field_lo(row, data_bits) +: data_bits];

  // Popcount of lt[row][*]; equal values order the newer (lower index) entry first.
  always_comb begin
    rank = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (j != row) begin
        if ((win[field_lo(j, data_bits) +: data_bits] < mine) ||
            ((win[field_lo(j, data_bits) +: data_bits] == mine) && (j < row))) begin
          rank = rank + rank_bits'(1);
        end
      end
    end
  end

endmodule

// File: rtl/rank_window_ranker.sv
// Sliding window of the last N samples with a unique rank per entry.
// Three-step pipeline (window, stage A, stage B) that stalls as a whole.
module rank_window_ranker
  import rof_pkg::*;
#(
  parameter int unsigned N         = RofN,
  parameter int unsigned data_bits = RofDataBits,
  parameter int unsigned rank_bits = RofRankBits
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [data_bits-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [data_bits*N-1:0] s,
  output logic [rank_bits*N-1:0] r
);

  localparam int unsigned CntW = clog2(N + 1);

  logic [data_bits*N-1:0] win_q;
  logic [CntW-1:0]        fill_cnt_q;
  logic                   w_new_q;
  logic                   a_vld_q;
  logic [data_bits*N-1:0] a_win_q;
  logic [rank_bits*N-1:0] rank_c;
  logic                   advance;
  logic                   accept;

  // Whole pipeline moves together; a flush swallows the offered sample.
  always_comb begin
    advance  = !out_valid || out_ready;
    in_ready = rst_n && advance;
    accept   = in_valid && advance && !flush;
  end

  // Window shift register, field 0 newest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else if (accept) begin
      win_q <= {win_q[data_bits*(N-1)-1:0], in_data};
    end
  end

  // Fill tracking; w_new marks a freshly completed window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt_q <= '0;
      w_new_q    <= 1'b0;
    end else if (flush) begin
      fill_cnt_q <= '0;
      w_new_q    <= 1'b0;
    end else if (advance) begin
      w_new_q <= accept && (fill_cnt_q >= CntW'(N - 1));
      if (accept && (fill_cnt_q != CntW'(N))) begin
        fill_cnt_q <= fill_cnt_q + CntW'(1);
      end
    end
  end

  // Stage A: snapshot the window for ranking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld_q <= 1'b0;
      a_win_q <= '0;
    end else if (flush) begin
      a_vld_q <= 1'b0;
    end else if (advance) begin
      a_vld_q <= w_new_q;
      a_win_q <= win_q;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_rank
    rank_counter #(
      .N         (N),
      .data_bits (data_bits),
      .rank_bits (rank_bits),
      .row       (gi)
    ) u_rank_counter (
      .win  (a_win_q),
      .rank (rank_c[field_lo(gi, rank_bits) +: rank_bits])
    );
  end

  // Stage B: register window and ranks for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      r         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= a_vld_q;
      s         <= a_win_q;
      r         <= rank_c;
    end
  end

endmodule

// File: tb/tb_rank_window_ranker.sv
// Bench for rank_window_ranker: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_rank_window_ranker;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned RW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [DW*N-1:0] s;
  logic [RW*N-1:0] r;

  int errors = 0;
  int checks = 0;

  rank_window_ranker #(
    .N         (N),
    .data_bits (DW),
    .rank_bits (RW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .r         (r)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [DW*N-1:0] s;
    logic [RW*N-1:0] r;
    int              age;
  } ent_t;

  logic [DW-1:0] hist[$];   // accepted samples since reset/flush, oldest first
  ent_t          pipe[$];   // completed windows in flight, age = advances since accept
  bit            exp_ov;
  bit            adv;

  // Ranks by repeated selection of the smallest unranked entry (lowest index wins ties).
  function automatic ent_t mk_entry();
    ent_t          e;
    logic [DW-1:0] v[N];
    bit            used[N];
    int            best;
    e.s   = '0;
    e.r   = '0;
    e.age = 0;
    for (int i = 0; i < N; i++) begin
      v[i]    = hist[hist.size() - 1 - i];
      used[i] = 1'b0;
      e.s[i*DW +: DW] = v[i];
    end
    for (int k = 0; k < N; k++) begin
      best = -1;
      for (int i = 0; i < N; i++) begin
        if (!used[i] && (best < 0 || v[i] < v[best])) best = i;
      end
      used[best] = 1'b1;
      e.r[best*RW +: RW] = RW'(k);
    end
    return e;
  endfunction

  // Compare outputs every cycle, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hist.delete();
      pipe.delete();
    end else begin
      exp_ov = (pipe.size() > 0) && (pipe[0].age == 2);
      check("model_out_valid", 32'(out_valid), 32'(exp_ov));
      check("model_in_ready", 32'(in_ready), 32'(!exp_ov || out_ready));
      if (exp_ov && out_valid) begin
        check("model_s", 32'(s), 32'(pipe[0].s));
        check("model_r", 32'(r), 32'(pipe[0].r));
      end
      adv = !exp_ov || out_ready;
      if (flush) begin
        hist.delete();
        pipe.delete();
      end else if (adv) begin
        if (exp_ov) void'(pipe.pop_front());
        foreach (pipe[k]) pipe[k].age = pipe[k].age + 1;
        if (in_valid) begin
          hist.push_back(in_data);
          if (hist.size() > N) void'(hist.pop_front());
          if (hist.size() == N) pipe.push_back(mk_entry());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush    = 1'b1;
    in_valid = 1'b0;
    cyc();
    flush = 1'b0;
  endtask

  // Fill three samples from empty; checks latency and literal window/ranks.
  task automatic fill3(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c, input logic [DW*N-1:0] es,
                       input logic [RW*N-1:0] er);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = a;
    cyc();
    check({name, "_nofill1"}, 32'(out_valid), 32'd0);
    in_data = b;
    cyc();
    check({name, "_nofill2"}, 32'(out_valid), 32'd0);
    in_data = c;
    cyc();
    in_valid = 1'b0;
    check({name, "_lat0"}, 32'(out_valid), 32'd0);
    cyc();
    check({name, "_lat1"}, 32'(out_valid), 32'd0);
    cyc();
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_s"}, 32'(s), 32'(es));
    check({name, "_r"}, 32'(r), 32'(er));
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    #1 rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    cyc();

    // 1: basic fill
    fill3("t1", 8'd5, 8'd1, 8'd9, {8'd5, 8'd1, 8'd9}, {2'd1, 2'd0, 2'd2});
    cyc();

    // 2: ties
    do_flush();
    fill3("t2", 8'd7, 8'd7, 8'd7, {8'd7, 8'd7, 8'd7}, {2'd2, 2'd1, 2'd0});
    cyc();

    // 3: partial fill then completion
    do_flush();
    in_valid = 1'b1;
    in_data  = 8'd3;
    cyc();
    in_data = 8'd8;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("t3_idle", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b1;
    in_data  = 8'd4;
    cyc();
    in_valid = 1'b0;
    cyc();
    check("t3_lat1", 32'(out_valid), 32'd0);
    cyc();
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_s", 32'(s), 32'({8'd3, 8'd8, 8'd4}));
    check("t3_r", 32'(r), 32'({2'd0, 2'd2, 2'd1}));
    cyc();

    // 4: backpressure
    do_flush();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'd10;
    cyc();
    in_data = 8'd20;
    cyc();
    in_data = 8'd30;
    cyc();
    in_data = 8'd40;
    cyc();
    in_valid = 1'b0;
    cyc();
    check("t4_first_valid", 32'(out_valid), 32'd1);
    check("t4_first_s", 32'(s), 32'({8'd10, 8'd20, 8'd30}));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd99;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_ready", 32'(in_ready), 32'd0);
      check("t4_hold_s", 32'(s), 32'({8'd10, 8'd20, 8'd30}));
      check("t4_hold_r", 32'(r), 32'({2'd0, 2'd1, 2'd2}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    check("t4_next_valid", 32'(out_valid), 32'd1);
    check("t4_next_s", 32'(s), 32'({8'd20, 8'd30, 8'd40}));
    check("t4_next_r", 32'(r), 32'({2'd0, 2'd1, 2'd2}));
    cyc();
    check("t4_drained", 32'(out_valid), 32'd0);

    // 5: flush with a full window drops the offered sample
    in_valid = 1'b1;
    in_data  = 8'd77;
    flush    = 1'b1;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("t5_flush_valid", 32'(out_valid), 32'd0);
    fill3("t5", 8'd1, 8'd2, 8'd3, {8'd1, 8'd2, 8'd3}, {2'd0, 2'd1, 2'd2});
    cyc();

    // Randomized traffic, model-checked every cycle
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = (i < 750) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      cyc();
    end
    flush = 1'b0;

    // 6: async reset while streaming
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(i + 40);
      cyc();
    end
    check("t6_streaming", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    cyc();
    fill3("t6", 8'd5, 8'd1, 8'd9, {8'd5, 8'd1, 8'd9}, {2'd1, 2'd0, 2'd2});
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
